// File: rtl/softcore_multi_timer.sv
// Multi-channel interval timer, Avalon-MM slave with per-channel prescaler,
// snapshot register, W1C pending register and per-channel/ORed interrupts.
module softcore_multi_timer #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int DATA_W     = 32,
    parameter int RST_PERIOD = 49999,
    parameter int ADDR_W     = $clog2(NUM_CH*4+1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam logic [ADDR_W-1:0] PEND_A = ADDR_W'(4*NUM_CH);
    localparam logic [CNT_W-1:0]  RST_P  = CNT_W'(RST_PERIOD);

    logic              wr;
    logic              pend_wr;
    logic [NUM_CH-1:0] to_vec;
    logic [DATA_W-1:0] rd_ch [NUM_CH];
    logic [DATA_W-1:0] readdata_q, readdata_d;

    assign wr      = chipselect & ~write_n;
    assign pend_wr = wr & (address == PEND_A);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [ADDR_W-1:0] BASE = ADDR_W'(4*c);

        logic             sel;
        logic             st_wr, ctl_wr, per_wr, snp_wr;
        logic             tick, evt, clr;
        logic [11:0]      ctrl_q, ctrl_d;
        logic [7:0]       pre_q, pre_d;
        logic [CNT_W-1:0] per_q, per_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] snap_q, snap_d;
        logic             run_q, run_d;
        logic             to_q, to_d;
        logic             z_q;
        logic [DATA_W-1:0] rd_val;

        assign sel    = address[ADDR_W-1:2] == BASE[ADDR_W-1:2];
        assign st_wr  = wr & sel & (address[1:0] == 2'd0);
        assign ctl_wr = wr & sel & (address[1:0] == 2'd1);
        assign per_wr = wr & sel & (address[1:0] == 2'd2);
        assign snp_wr = wr & sel & (address[1:0] == 2'd3);

        assign tick = (pre_q == 8'd0);
        // z_q remembers counter==0 from the previous clock for edge detection
        assign evt  = (cnt_q == '0) & ~z_q;
        assign clr  = st_wr | (pend_wr & writedata[c]);

        always_comb begin
            ctrl_d = ctrl_q;
            pre_d  = tick ? ctrl_q[11:4] : pre_q - 8'd1;
            per_d  = per_q;
            cnt_d  = cnt_q;
            snap_d = snap_q;
            run_d  = run_q;
            to_d   = evt ? 1'b1 : (clr ? 1'b0 : to_q);
            if (run_q && tick) begin
                if (cnt_q == '0) begin
                    cnt_d = per_q;
                    if (!ctrl_q[1])
                        run_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            if (ctl_wr) begin
                ctrl_d = writedata[11:0];
                if (writedata[2]) begin
                    run_d = 1'b1;
                    pre_d = writedata[11:4];
                end else if (writedata[3]) begin
                    run_d = 1'b0;
                end
            end
            if (per_wr) begin
                per_d = writedata[CNT_W-1:0];
                cnt_d = writedata[CNT_W-1:0];
                run_d = 1'b0;
                pre_d = ctrl_q[11:4];
            end
            if (snp_wr)
                snap_d = cnt_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ctrl_q <= '0;
                pre_q  <= '0;
                per_q  <= RST_P;
                cnt_q  <= RST_P;
                snap_q <= '0;
                run_q  <= 1'b0;
                to_q   <= 1'b0;
                z_q    <= 1'b0;
            end else begin
                ctrl_q <= ctrl_d;
                pre_q  <= pre_d;
                per_q  <= per_d;
                cnt_q  <= cnt_d;
                snap_q <= snap_d;
                run_q  <= run_d;
                to_q   <= to_d;
                z_q    <= (cnt_q == '0);
            end
        end

        always_comb begin
            rd_val = '0;
            if (sel) begin
                unique case (address[1:0])
                    2'd0:    rd_val = DATA_W'({run_q, to_q});
                    2'd1:    rd_val = DATA_W'(ctrl_q);
                    2'd2:    rd_val = DATA_W'(per_q);
                    default: rd_val = DATA_W'(snap_q);
                endcase
            end
        end

        assign rd_ch[c]   = rd_val;
        assign to_vec[c]  = to_q;
        assign irq_vec[c] = to_q & ctrl_q[0];
    end

    always_comb begin
        readdata_d = '0;
        for (int c = 0; c < NUM_CH; c++)
            readdata_d = readdata_d | rd_ch[c];
        if (address == PEND_A)
            readdata_d = DATA_W'(to_vec);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata_q <= '0;
        else
            readdata_q <= readdata_d;
    end

    assign readdata = readdata_q;
    assign irq      = |irq_vec;

endmodule
